// File: rtl/key_pulse_conditioner_if.sv
// rtl/key_pulse_conditioner_if.sv - raw pushbutton inputs and conditioned pulse outputs
interface key_pulse_conditioner_if;
    logic       right_key_n;
    logic       up_key_n;
    logic       down_key_n;
    logic       right_pulse;
    logic       up_pulse;
    logic       down_pulse;
    logic [2:0] key_level;

    modport master (
        output right_key_n, up_key_n, down_key_n,
        input  right_pulse, up_pulse, down_pulse, key_level
    );

    modport slave (
        input  right_key_n, up_key_n, down_key_n,
        output right_pulse, up_pulse, down_pulse, key_level
    );
endinterface

// File: rtl/key_pulse_conditioner.sv
// rtl/key_pulse_conditioner.sv - synchronise, debounce, edge-pulse and auto-repeat three pushbuttons
// Channel index 0=right, 1=up, 2=down throughout.
module key_pulse_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000,
    parameter logic [2:0]  REPEAT_EN       = 3'b110,
    parameter bit          LOCKOUT         = 1'b1,
    parameter int unsigned CNT_W           = 25
) (
    input  logic                     clk,
    input  logic                     rst_n,
    key_pulse_conditioner_if.slave   keys
);
    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_ACCEPTED,
        ST_REPEAT,
        ST_REJECTED
    } state_e;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [2:0]       raw_n;
    logic [2:0]       sync1_q, sync2_q;
    logic [2:0]       level_q, level_d;
    logic [2:0]       pulse_q, pulse_d;
    logic [2:0]       rise, fall, active, blocked;
    logic [CNT_W-1:0] db_cnt_q   [3];
    logic [CNT_W-1:0] db_cnt_d   [3];
    logic [CNT_W-1:0] hold_cnt_q [3];
    logic [CNT_W-1:0] hold_cnt_d [3];
    state_e           state_q    [3];
    state_e           state_d    [3];

    assign raw_n = {keys.down_key_n, keys.up_key_n, keys.right_key_n};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
            level_q <= 3'b000;
            pulse_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i]   <= '0;
                hold_cnt_q[i] <= '0;
                state_q[i]    <= ST_RELEASED;
            end
        end else begin
            sync1_q <= raw_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i]   <= db_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
                state_q[i]    <= state_d[i];
            end
        end
    end

    // Level edges are decoded from the same compare that toggles the level,
    // so the press pulse registers on the same edge as the level rise.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            level_d[i]  = level_q[i];
            db_cnt_d[i] = '0;
            rise[i]     = 1'b0;
            fall[i]     = 1'b0;
            if ((~sync2_q[i]) != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i] = ~level_q[i];
                    rise[i]    = ~level_q[i];
                    fall[i]    = level_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            active[i] = (state_q[i] == ST_ACCEPTED) || (state_q[i] == ST_REPEAT);
        end
    end

    // Lower index wins simultaneous rises; any accepted/repeating key blocks the rest.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            blocked[i] = 1'b0;
            for (int j = 0; j < 3; j++) begin
                if (LOCKOUT && (j != i) && (active[j] || ((j < i) && rise[j]))) begin
                    blocked[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i]    = state_q[i];
            hold_cnt_d[i] = hold_cnt_q[i];
            pulse_d[i]    = 1'b0;
            case (state_q[i])
                ST_RELEASED: begin
                    if (rise[i]) begin
                        hold_cnt_d[i] = '0;
                        if (blocked[i]) begin
                            state_d[i] = ST_REJECTED;
                        end else begin
                            state_d[i] = ST_ACCEPTED;
                            pulse_d[i] = 1'b1;
                        end
                    end
                end
                ST_ACCEPTED: begin
                    if (fall[i]) begin
                        state_d[i]    = ST_RELEASED;
                        hold_cnt_d[i] = '0;
                    end else if (REPEAT_EN[i]) begin
                        if (hold_cnt_q[i] == DLY_LAST) begin
                            state_d[i]    = ST_REPEAT;
                            hold_cnt_d[i] = '0;
                            pulse_d[i]    = 1'b1;
                        end else begin
                            hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (fall[i]) begin
                        state_d[i]    = ST_RELEASED;
                        hold_cnt_d[i] = '0;
                    end else if (hold_cnt_q[i] == PER_LAST) begin
                        hold_cnt_d[i] = '0;
                        pulse_d[i]    = 1'b1;
                    end else begin
                        hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
                    end
                end
                ST_REJECTED: begin
                    if (fall[i]) begin
                        state_d[i]    = ST_RELEASED;
                        hold_cnt_d[i] = '0;
                    end
                end
                default: begin
                    state_d[i]    = ST_RELEASED;
                    hold_cnt_d[i] = '0;
                end
            endcase
        end
    end

    assign keys.right_pulse = pulse_q[0];
    assign keys.up_pulse    = pulse_q[1];
    assign keys.down_pulse  = pulse_q[2];
    assign keys.key_level   = level_q;
endmodule

// File: tb/tb_key_pulse_conditioner.sv
// tb/tb_key_pulse_conditioner.sv - scoreboard bench for key_pulse_conditioner (lockout and independent variants)
module tb_key_pulse_conditioner;
    typedef struct {
        int unsigned edge_no;
        logic [2:0]  keys;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mon_en;
    int unsigned edge_n = 0;
    int unsigned base;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb_q[$];
    exp_t        sb2_q[$];
    exp_t        e1, e2;
    logic [2:0]  p1, p2;

    key_pulse_conditioner_if kif();
    key_pulse_conditioner_if kif2();

    key_pulse_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3),
        .REPEAT_EN(3'b110), .LOCKOUT(1'b1), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .keys(kif.slave)
    );

    key_pulse_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3),
        .REPEAT_EN(3'b110), .LOCKOUT(1'b0), .CNT_W(8)
    ) dut_free (
        .clk(clk), .rst_n(rst_n), .keys(kif2.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push1(input int unsigned e, input logic [2:0] k);
        exp_t x;
        x.edge_no = e;
        x.keys    = k;
        sb_q.push_back(x);
    endtask

    task automatic push2(input int unsigned e, input logic [2:0] k);
        exp_t x;
        x.edge_no = e;
        x.keys    = k;
        sb2_q.push_back(x);
    endtask

    task automatic wait_edge(input int unsigned e);
        while (edge_n < e) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            p1 = {kif.down_pulse, kif.up_pulse, kif.right_pulse};
            if (p1 != 3'b000) begin
                if (sb_q.size() == 0) begin
                    check_eq("lock_unexpected_pulse", 32'(p1), 32'd0);
                end else begin
                    e1 = sb_q.pop_front();
                    check_eq("lock_pulse_edge", edge_n, e1.edge_no);
                    check_eq("lock_pulse_keys", 32'(p1), 32'(e1.keys));
                end
            end
            p2 = {kif2.down_pulse, kif2.up_pulse, kif2.right_pulse};
            if (p2 != 3'b000) begin
                if (sb2_q.size() == 0) begin
                    check_eq("free_unexpected_pulse", 32'(p2), 32'd0);
                end else begin
                    e2 = sb2_q.pop_front();
                    check_eq("free_pulse_edge", edge_n, e2.edge_no);
                    check_eq("free_pulse_keys", 32'(p2), 32'(e2.keys));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        kif.right_key_n  = 1'b1;
        kif.up_key_n     = 1'b1;
        kif.down_key_n   = 1'b1;
        kif2.right_key_n = 1'b1;
        kif2.up_key_n    = 1'b1;
        kif2.down_key_n  = 1'b1;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_level", 32'(kif.key_level), 32'd0);
        check_eq("reset_pulses", 32'({kif.down_pulse, kif.up_pulse, kif.right_pulse}), 32'd0);
        check_eq("reset_level_free", 32'(kif2.key_level), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        // up held: press at +5, first repeat at +15, then every 3
        base = edge_n + 1;
        kif.up_key_n = 1'b0;
        push1(base + 5, 3'b010);
        for (int t = 15; t <= 30; t += 3) push1(base + t, 3'b010);
        wait_edge(base + 4);
        check_eq("t1_level_before", 32'(kif.key_level), 32'd0);
        wait_edge(base + 5);
        check_eq("t1_level_rise", 32'(kif.key_level), 32'b010);
        wait_edge(base + 25);
        kif.up_key_n = 1'b1;
        wait_edge(base + 40);
        check_eq("t1_drain", sb_q.size(), 0);
        check_eq("t1_level_released", 32'(kif.key_level), 32'd0);

        // right bounces every 2 cycles, then settles low
        for (int b = 0; b < 5; b++) begin
            kif.right_key_n = 1'b0;
            repeat (2) @(negedge clk);
            kif.right_key_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        check_eq("t2_level_bounce", 32'(kif.key_level), 32'd0);
        base = edge_n + 1;
        kif.right_key_n = 1'b0;
        push1(base + 5, 3'b001);
        wait_edge(base + 20);
        check_eq("t2_level_held", 32'(kif.key_level), 32'b001);
        kif.right_key_n = 1'b1;
        wait_edge(base + 35);
        check_eq("t2_drain", sb_q.size(), 0);

        // right and down together: right wins, down stays silent until re-pressed
        base = edge_n + 1;
        kif.right_key_n = 1'b0;
        kif.down_key_n  = 1'b0;
        push1(base + 5, 3'b001);
        wait_edge(base + 8);
        kif.right_key_n = 1'b1;
        wait_edge(base + 25);
        check_eq("t3_down_level_held", 32'(kif.key_level), 32'b100);
        kif.down_key_n = 1'b1;
        wait_edge(base + 35);
        check_eq("t3_drain_rejected", sb_q.size(), 0);
        base = edge_n + 1;
        kif.down_key_n = 1'b0;
        push1(base + 5, 3'b100);
        wait_edge(base + 6);
        kif.down_key_n = 1'b1;
        wait_edge(base + 20);
        check_eq("t3_drain_repress", sb_q.size(), 0);

        // up accepted, down pressed later is locked out; up repeats continue
        base = edge_n + 1;
        kif.up_key_n = 1'b0;
        push1(base + 5, 3'b010);
        for (int t = 15; t <= 24; t += 3) push1(base + t, 3'b010);
        wait_edge(base + 6);
        kif.down_key_n = 1'b0;
        wait_edge(base + 19);
        kif.up_key_n   = 1'b1;
        kif.down_key_n = 1'b1;
        wait_edge(base + 20);
        check_eq("t4_level_both", 32'(kif.key_level), 32'b110);
        wait_edge(base + 35);
        check_eq("t4_drain", sb_q.size(), 0);

        // reset in REPEAT with key held: silent through reset, then fresh press timing
        base = edge_n + 1;
        kif.up_key_n = 1'b0;
        push1(base + 5, 3'b010);
        push1(base + 15, 3'b010);
        push1(base + 18, 3'b010);
        push1(base + 27, 3'b010);
        push1(base + 37, 3'b010);
        push1(base + 40, 3'b010);
        push1(base + 43, 3'b010);
        wait_edge(base + 19);
        rst_n = 1'b0;
        wait_edge(base + 20);
        check_eq("t5_reset_level", 32'(kif.key_level), 32'd0);
        check_eq("t5_reset_pulse", 32'(kif.up_pulse), 32'd0);
        wait_edge(base + 21);
        rst_n = 1'b1;
        wait_edge(base + 38);
        kif.up_key_n = 1'b1;
        wait_edge(base + 55);
        check_eq("t5_drain", sb_q.size(), 0);

        // no lockout: simultaneous up and down both pulse
        base = edge_n + 1;
        kif2.up_key_n   = 1'b0;
        kif2.down_key_n = 1'b0;
        push2(base + 5, 3'b110);
        wait_edge(base + 5);
        check_eq("t6_level", 32'(kif2.key_level), 32'b110);
        wait_edge(base + 6);
        kif2.up_key_n   = 1'b1;
        kif2.down_key_n = 1'b1;
        wait_edge(base + 20);
        check_eq("t6_drain_free", sb2_q.size(), 0);
        check_eq("t6_drain_lock", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
